// File: rtl/accel_pkg.sv
// Types and constants shared by the accelerator's host link, loader and compute side.
// Elements are Q8.24 fixed point, carried as raw 32-bit words.
package accel_pkg;

    localparam int unsigned BAUD_TICKS_DEFAULT = 10;

    typedef logic [31:0] q8_24_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    typedef enum logic [1:0] {
        L_IDLE,
        L_LOAD_A,
        L_LOAD_B,
        L_DONE
    } loader_state_e;

endpackage

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: 2-FF synchroniser and a mid-bit sampling FSM.
// Emits one-cycle valid or frame_err pulses; data_o holds the last shifted byte.
module uart_rx_8n1
    import accel_pkg::*;
#(
    parameter int unsigned BAUD_TICKS = BAUD_TICKS_DEFAULT
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       frame_err_o
);

    localparam int unsigned TICK_W = $clog2(BAUD_TICKS);
    localparam logic [TICK_W-1:0] HALF_LOAD = TICK_W'(BAUD_TICKS / 2 - 1);
    localparam logic [TICK_W-1:0] FULL_LOAD = TICK_W'(BAUD_TICKS - 1);

    logic              sync1_q, sync2_q;
    rx_state_e         state_q, state_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              valid_q, valid_d;
    logic              ferr_q, ferr_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= RX_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (!sync2_q) begin
                    state_d = RX_START;
                    tick_d  = HALF_LOAD;
                end
            end
            RX_START: begin
                if (tick_q == '0) begin
                    // A start bit that is gone by mid-bit is treated as a glitch.
                    if (!sync2_q) begin
                        state_d = RX_DATA;
                        tick_d  = FULL_LOAD;
                        bit_d   = '0;
                    end else begin
                        state_d = RX_IDLE;
                    end
                end else begin
                    tick_d = tick_q - 1'b1;
                end
            end
            RX_DATA: begin
                if (tick_q == '0) begin
                    shift_d = {sync2_q, shift_q[7:1]};
                    tick_d  = FULL_LOAD;
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    tick_d = tick_q - 1'b1;
                end
            end
            RX_STOP: begin
                if (tick_q == '0) begin
                    // Leave at mid stop bit so an immediately following start bit is seen.
                    if (sync2_q) begin
                        valid_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                    state_d = RX_IDLE;
                end else begin
                    tick_d = tick_q - 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign data_o      = shift_q;
    assign valid_o     = valid_q;
    assign frame_err_o = ferr_q;

endmodule

// File: rtl/uart_matrix_loader.sv
// Loads matrices A then B from the host UART into the operand buffers, one
// little-endian Q8.24 element per ELEM_BYTES bytes, and pulses load_done_out at the end.
module uart_matrix_loader
    import accel_pkg::*;
#(
    parameter int unsigned BAUD_TICKS = BAUD_TICKS_DEFAULT,
    parameter int unsigned N_ELEMS    = 9,
    parameter int unsigned ELEM_BYTES = 4,
    parameter int unsigned ADDR_W     = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              arm_in,
    input  logic              rx_in,
    output logic              wr_en_out,
    output logic              wr_sel_out,
    output logic [ADDR_W-1:0] wr_addr_out,
    output logic [31:0]       wr_data_out,
    output logic              load_done_out,
    output logic              busy_out,
    output logic              frame_err_out
);

    localparam int unsigned BCNT_W = $clog2(ELEM_BYTES);
    localparam int unsigned ASM_W  = (ELEM_BYTES - 1) * 8;

    logic       rx_valid;
    logic       rx_ferr;
    logic [7:0] rx_data;

    uart_rx_8n1 #(
        .BAUD_TICKS (BAUD_TICKS)
    ) u_rx (
        .clk_i       (clk_in),
        .rst_ni      (rst_in),
        .rx_i        (rx_in),
        .data_o      (rx_data),
        .valid_o     (rx_valid),
        .frame_err_o (rx_ferr)
    );

    loader_state_e     state_q, state_d;
    logic [BCNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [ADDR_W-1:0] elem_cnt_q, elem_cnt_d;
    logic [ASM_W-1:0]  asm_q, asm_d;
    logic              wr_en_q, wr_en_d;
    logic              wr_sel_q, wr_sel_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    q8_24_t            wr_data_q, wr_data_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              ferr_q, ferr_d;

    // Only the earlier bytes are kept; the final byte completes the word on the fly.
    q8_24_t asm_word;
    assign asm_word = {rx_data, asm_q};

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= L_IDLE;
            byte_cnt_q <= '0;
            elem_cnt_q <= '0;
            asm_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_sel_q   <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            elem_cnt_q <= elem_cnt_d;
            asm_q      <= asm_d;
            wr_en_q    <= wr_en_d;
            wr_sel_q   <= wr_sel_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            ferr_q     <= ferr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        elem_cnt_d = elem_cnt_q;
        asm_d      = asm_q;
        wr_en_d    = 1'b0;
        wr_sel_d   = wr_sel_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        done_d     = 1'b0;
        busy_d     = busy_q;
        ferr_d     = ferr_q;
        case (state_q)
            L_IDLE: begin
                if (arm_in) begin
                    state_d    = L_LOAD_A;
                    busy_d     = 1'b1;
                    ferr_d     = 1'b0;
                    byte_cnt_d = '0;
                    elem_cnt_d = '0;
                end
            end
            L_LOAD_A, L_LOAD_B: begin
                if (rx_valid) begin
                    asm_d = asm_word[31:8];
                    if (byte_cnt_q == BCNT_W'(ELEM_BYTES - 1)) begin
                        byte_cnt_d = '0;
                        wr_en_d    = 1'b1;
                        wr_data_d  = asm_word;
                        wr_addr_d  = elem_cnt_q;
                        wr_sel_d   = (state_q == L_LOAD_B);
                        if (elem_cnt_q == ADDR_W'(N_ELEMS - 1)) begin
                            elem_cnt_d = '0;
                            state_d    = (state_q == L_LOAD_A) ? L_LOAD_B : L_DONE;
                        end else begin
                            elem_cnt_d = elem_cnt_q + 1'b1;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end
            L_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = L_IDLE;
            end
            default: state_d = L_IDLE;
        endcase
        // A bad stop bit wins over a same-cycle arm so it is never lost.
        if (rx_ferr) begin
            ferr_d = 1'b1;
        end
    end

    assign wr_en_out     = wr_en_q;
    assign wr_sel_out    = wr_sel_q;
    assign wr_addr_out   = wr_addr_q;
    assign wr_data_out   = wr_data_q;
    assign load_done_out = done_q;
    assign busy_out      = busy_q;
    assign frame_err_out = ferr_q;

endmodule

// File: doc/uart_matrix_loader.md
Name: uart_matrix_loader

Overview:
- Upstream stage of the systolic accelerator. Deserialises the host UART line (8N1) and packs the bytes into 32-bit Q8.24 elements.
- Writes the elements into the A and B operand buffers in order: A first, then B.
- Raises a one-cycle `load_done` once both matrices are complete; the compute FSM then starts on that signal.

Parameters:
- BAUD_TICKS, 10, clock cycles per UART bit (minimum 4)
- N_ELEMS, 9, elements per matrix (3x3)
- ELEM_BYTES, 4, bytes per element (Q8.24 = 32 bits)
- ADDR_W, 4, element address width; must satisfy N_ELEMS <= 2**ADDR_W

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  asynchronous, active-low reset
- arm_in  in  1  one-cycle pulse; starts a new A+B load sequence
- rx_in  in  1  UART serial input, idles high
- wr_en_out  out  1  element write strobe, one cycle per element
- wr_sel_out  out  1  target matrix: 0 = A, 1 = B
- wr_addr_out  out  ADDR_W  element index 0..N_ELEMS-1, row-major
- wr_data_out  out  32  assembled Q8.24 element
- load_done_out  out  1  one-cycle pulse after the last B element is written
- busy_out  out  1  high from arm until load_done_out
- frame_err_out  out  1  sticky; set on a bad stop bit, cleared by arm_in

Behaviour:
- Reset (rst_in = 0, asynchronous): all outputs 0, both FSMs idle, counters 0, byte shift register 0.
- rx_in passes through a 2-FF synchroniser reset to 1. All detection below uses the synchronised signal (2-cycle input latency).
- Receiver FSM states: RX_IDLE, RX_START, RX_DATA, RX_STOP.
  - RX_IDLE -> RX_START on synchronised rx = 0; load the tick counter.
  - RX_START: after BAUD_TICKS/2 ticks, sample the line.
    - Line 0: go to RX_DATA.
    - Line 1: glitch; return to RX_IDLE with no byte.
  - RX_DATA: sample every BAUD_TICKS ticks, LSB first, 8 bits, then go to RX_STOP.
  - RX_STOP: sample after BAUD_TICKS ticks.
    - Line 1: emit internal byte_valid for one cycle.
    - Line 0: set frame_err_out and drop the byte.
  - In both RX_STOP cases, return to RX_IDLE immediately, at mid stop bit, so a back-to-back start bit is caught.
- The receiver runs whether or not the block is armed. Bytes arriving while the loader is idle or done are discarded.
- Loader FSM states: L_IDLE, L_LOAD_A, L_LOAD_B, L_DONE.
  - L_IDLE: on arm_in, go to L_LOAD_A; busy = 1; clear frame_err_out, byte counter and element counter.
  - L_LOAD_A / L_LOAD_B: each byte_valid shifts the byte into a 32-bit assembler, little-endian (first byte = bits [7:0], fourth byte = [31:24]).
  - On the ELEM_BYTES-th byte, in the cycle after byte_valid:
    - pulse wr_en_out;
    - wr_data_out = assembled word; wr_addr_out = element counter; wr_sel_out = current matrix;
    - increment the element counter.
  - Element counter reaching N_ELEMS in L_LOAD_A: reset it to 0 and go to L_LOAD_B.
  - Element counter reaching N_ELEMS in L_LOAD_B: go to L_DONE.
  - L_DONE: pulse load_done_out for one cycle, drop busy_out, return to L_IDLE.
- Outputs are registered. wr_data/addr/sel hold their last values when wr_en_out = 0.
- arm_in while busy is ignored (no restart).
- A framing error does not advance the byte counter, so the sequence resumes with the next good byte. Host-side resync is the host's responsibility.
- A reset mid-frame or mid-load abandons everything; no write is issued for partial elements.

Decomposition:
- Shared package `accel_pkg`:
  - Q8.24 element typedef (logic [31:0]);
  - loader and receiver state enums;
  - default BAUD_TICKS constant, shared with the TX side and the top level.
- One natural sub-module: `uart_rx_8n1`.
  - Contains the synchroniser and the receiver FSM.
  - Interface: data[7:0], valid, frame_err.
  - Reusable by other hosts of the link.
- The loader FSM stays in `uart_matrix_loader`.

Test Plan:
- Arm, then send bytes 0x78,0x56,0x34,0x12 at 10 clk/bit -> single wr_en_out with sel=0, addr=0, data=0x12345678.
- Arm, then send 72 bytes k=0..71 -> 9 writes with sel=0, then 9 with sel=1, addr 0..8 each.
  - A[8] = 0x23222120; B[0] = 0x27262524.
  - load_done_out pulses exactly once, 1 cycle after the last write; busy_out falls with it.
- Send one byte with stop bit = 0, then good bytes -> frame_err_out = 1 and no counter advance; the next 4 good bytes form element 0.
- 2-cycle low glitch on rx_in while idle -> no byte_valid and no write; the following real byte is received correctly.
- Assert rst_in low mid-byte during L_LOAD_B -> all outputs 0 immediately. After release, bytes before arm produce no writes; re-arm and a full 72-byte load completes normally.
- Pulse arm_in again during L_LOAD_A -> ignored; the element sequence and addresses continue unchanged.
